// File: rtl/out_monitor.sv
// Monitors a 1-bit stream. It produces registered rise/fall pulses, detects the
// overlapping pattern 1011, and keeps saturating high/rise/run statistics.
module out_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             out_in,
  output logic             rise,
  output logic             fall,
  output logic             det,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] run_len
);

  typedef enum logic [1:0] {S0, S1, S10, S101} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             have_prev_q, have_prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] run_q, run_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    have_prev_d = have_prev_q;
    high_d      = high_q;
    rcnt_d      = rcnt_q;
    run_d       = run_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    det_d       = 1'b0;
    if (clear) begin
      // The sample on a clearing edge is discarded; last holds its value.
      state_d     = S0;
      have_prev_d = 1'b0;
      high_d      = '0;
      rcnt_d      = '0;
      run_d       = '0;
    end else if (en) begin
      rise_d      = have_prev_q & ~last_q & out_in;
      fall_d      = have_prev_q & last_q & ~out_in;
      last_d      = out_in;
      have_prev_d = 1'b1;
      if (out_in) begin
        high_d = sat_inc(high_q);
        run_d  = sat_inc(run_q);
      end else begin
        run_d  = '0;
      end
      if (rise_d) rcnt_d = sat_inc(rcnt_q);
      unique case (state_q)
        S0:   state_d = out_in ? S1 : S0;
        S1:   state_d = out_in ? S1 : S10;
        S10:  state_d = out_in ? S101 : S0;
        S101: begin
          state_d = out_in ? S1 : S10;
          det_d   = out_in;
        end
        default: state_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S0;
      last_q      <= 1'b0;
      have_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      det_q       <= 1'b0;
      high_q      <= '0;
      rcnt_q      <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      have_prev_q <= have_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      det_q       <= det_d;
      high_q      <= high_d;
      rcnt_q      <= rcnt_d;
      run_q       <= run_d;
    end
  end

  assign rise     = rise_q;
  assign fall     = fall_q;
  assign det      = det_q;
  assign high_cnt = high_q;
  assign rise_cnt = rcnt_q;
  assign run_len  = run_q;

endmodule

// File: tb/tb_out_monitor.sv
// Scoreboard bench for out_monitor: directed vectors push hand-computed
// expectations; a monitor pops and compares one cycle after each sampled edge.
module tb_out_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clear = 1'b0, out_in = 1'b0;
  logic rise8, fall8, det8, rise3, fall3, det3;
  logic [7:0] high8, rcnt8, run8;
  logic [2:0] high3, rcnt3, run3;

  always #5 clk = ~clk;

  out_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .out_in(out_in),
    .rise(rise8), .fall(fall8), .det(det8),
    .high_cnt(high8), .rise_cnt(rcnt8), .run_len(run8)
  );

  out_monitor #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .out_in(out_in),
    .rise(rise3), .fall(fall3), .det(det3),
    .high_cnt(high3), .rise_cnt(rcnt3), .run_len(run3)
  );

  typedef struct packed {
    logic       sel3;
    logic       r, f, d;
    logic [7:0] h, rc, run;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  task automatic step(input logic r_i, input logic c_i, input logic e_i, input logic b_i,
                      input logic s3, input logic er, input logic ef, input logic ed,
                      input int eh, input int erc, input int erun);
    exp_t e;
    @(negedge clk);
    rst = r_i; clear = c_i; en = e_i; out_in = b_i;
    e.sel3 = s3; e.r = er; e.f = ef; e.d = ed;
    e.h = 8'(eh); e.rc = 8'(erc); e.run = 8'(erun);
    exp_q.push_back(e);
  endtask

  // Monitor: the expectation pushed before edge N is compared just after edge N.
  initial begin
    exp_t e;
    logic [26:0] act, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel3)
          act = {rise3, fall3, det3, 5'd0, high3, 5'd0, rcnt3, 5'd0, run3};
        else
          act = {rise8, fall8, det8, high8, rcnt8, run8};
        want = {e.r, e.f, e.d, e.h, e.rc, e.run};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL vec%0d dut%0s: got r=%b f=%b d=%b high=%0d rcnt=%0d run=%0d, want r=%b f=%b d=%b high=%0d rcnt=%0d run=%0d",
                   vec_id, e.sel3 ? "3" : "8", act[26], act[25], act[24], act[23:16], act[15:8], act[7:0],
                   e.r, e.f, e.d, e.h, e.rc, e.run);
        end
        vec_id++;
      end
    end
  end

  initial begin
    // Reset, then 1,0,1,1,0,1,1 followed by an idle cycle
    step(1,0,0,0, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);
    step(0,0,1,0, 0, 0,1,0, 1,0,0);
    step(0,0,1,1, 0, 1,0,0, 2,1,1);
    step(0,0,1,1, 0, 0,0,1, 3,1,2);
    step(0,0,1,0, 0, 0,1,0, 3,1,0);
    step(0,0,1,1, 0, 1,0,0, 4,2,1);
    step(0,0,1,1, 0, 0,0,1, 5,2,2);
    step(0,0,0,1, 0, 0,0,0, 5,2,2);

    // Enable gap: 1,0,1, five idle cycles, then 1 completes 1011
    step(1,0,0,0, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);
    step(0,0,1,0, 0, 0,1,0, 1,0,0);
    step(0,0,1,1, 0, 1,0,0, 2,1,1);
    for (int i = 0; i < 5; i++) step(0,0,0,0, 0, 0,0,0, 2,1,1);
    step(0,0,1,1, 0, 0,0,1, 3,1,2);

    // Clear with en=1 and out_in=1 discards the sample; next 1 gives no rise
    step(1,0,0,0, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);
    step(0,0,1,0, 0, 0,1,0, 1,0,0);
    step(0,0,1,1, 0, 1,0,0, 2,1,1);
    step(0,1,1,1, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);

    // Reset mid-stream with en=1, clear also high, then fresh 1,0,1,1
    step(1,0,0,0, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);
    step(0,0,1,0, 0, 0,1,0, 1,0,0);
    step(0,0,1,1, 0, 1,0,0, 2,1,1);
    step(1,1,1,1, 0, 0,0,0, 0,0,0);
    step(0,0,1,1, 0, 0,0,0, 1,0,1);
    step(0,0,1,0, 0, 0,1,0, 1,0,0);
    step(0,0,1,1, 0, 1,0,0, 2,1,1);
    step(0,0,1,1, 0, 0,0,1, 3,1,2);

    // CNT_W=3: nine ones saturate at 7, then a 0 clears only the run
    step(1,0,0,0, 1, 0,0,0, 0,0,0);
    for (int i = 1; i <= 9; i++) step(0,0,1,1, 1, 0,0,0, (i > 7) ? 7 : i, 0, (i > 7) ? 7 : i);
    step(0,0,1,0, 1, 0,1,0, 7,0,0);
    step(0,0,1,1, 1, 1,0,0, 7,1,1);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
